// File: rtl/dataflow_pkg.sv
// ---------------------------------------------------------------------------
// dataflow_pkg
// Shared types for the dataflow loop primitives. dataflow_stream and the
// other loop-control blocks take their FSM state encodings from here, so the
// encodings stay identical wherever they are decoded or traced.
//
// Contents:
//   stream_state_t  dataflow_stream FSM states (2-bit: IDLE=0, RUN=1, LAST=2)
//   STREAM_STATE_W  width of stream_state_t
// ---------------------------------------------------------------------------
package dataflow_pkg;

    localparam int unsigned STREAM_STATE_W = 2;

    typedef enum logic [STREAM_STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } stream_state_t;

endpackage : dataflow_pkg

// File: rtl/dataflow_stream_next.sv
// ---------------------------------------------------------------------------
// dataflow_stream_next
// Combinational advance/compare for the index stream: next = cur + step,
// evaluated at WIDTH+1 bits, and in_range = (next < bound) with overflow
// forcing in_range low regardless of bound.
//
// Configuration macro: LOOM_DATAFLOW_STREAM_SIGNED_EN
//   defined   : two's-complement compare, overflow = signed add overflow
//   undefined : unsigned compare, overflow = carry out of bit WIDTH-1
//
// Ports:
//   cur      in   WIDTH  current index
//   step     in   WIDTH  increment
//   bound    in   WIDTH  exclusive upper bound
//   next     out  WIDTH  cur + step (truncated)
//   in_range out  1      next is a valid iteration index
// ---------------------------------------------------------------------------
module dataflow_stream_next #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] bound,
    output logic [WIDTH-1:0] next,
    output logic             in_range
);

    logic [WIDTH:0] w_sum;
    logic           w_ovf;
    logic           w_lt;

    assign w_sum = {1'b0, cur} + {1'b0, step};
    assign next  = w_sum[WIDTH-1:0];

`ifdef LOOM_DATAFLOW_STREAM_SIGNED_EN
    // Signed overflow is carry-in to the MSB differing from carry-out;
    // carry-in to the MSB is recovered as cur^step^sum at that bit.
    assign w_ovf = w_sum[WIDTH] ^ (cur[WIDTH-1] ^ step[WIDTH-1] ^ w_sum[WIDTH-1]);
    assign w_lt  = $signed(next) < $signed(bound);
`else
    assign w_ovf = w_sum[WIDTH];
    assign w_lt  = next < bound;
`endif

    assign in_range = ~w_ovf & w_lt;

endmodule : dataflow_stream_next

// File: rtl/dataflow_stream.sv
// ---------------------------------------------------------------------------
// dataflow_stream
// Loop index generator. Accepts a {start, step, bound} triple as one joined
// handshake, then emits the index tokens start, start+step, ... while below
// bound on idx, and a will-continue token per iteration on cont (1 for each
// index, then a single 0). cont feeds loop gates / invariant done tokens.
//
// Configuration macro: LOOM_DATAFLOW_STREAM_SIGNED_EN (signed compare and
// signed overflow detection; default build is unsigned).
//
// Ports:
//   clk                      in   1      clock
//   rst_n                    in   1      asynchronous reset, active-low
//   start_valid/ready/data   in/out/in   first index value
//   step_valid/ready/data    in/out/in   increment
//   bound_valid/ready/data   in/out/in   exclusive upper bound
//   idx_valid/ready/data     out/in/out  per-iteration index token
//   cont_valid/ready/data    out/in/out  will-continue token (1 bit)
// ---------------------------------------------------------------------------
module dataflow_stream
    import dataflow_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_data,

    input  logic             step_valid,
    output logic             step_ready,
    input  logic [WIDTH-1:0] step_data,

    input  logic             bound_valid,
    output logic             bound_ready,
    input  logic [WIDTH-1:0] bound_data,

    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [WIDTH-1:0] idx_data,

    output logic             cont_valid,
    input  logic             cont_ready,
    output logic             cont_data
);

    stream_state_t    r_state;
    stream_state_t    w_state_nxt;

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_bound;
    logic             r_idx_sent;
    logic             r_cont_sent;

    logic             w_triple_vld;
    logic             w_capture;
    logic             w_idx_fire;
    logic             w_cont_fire;
    logic             w_idx_done;
    logic             w_cont_done;
    logic             w_advance;

    logic [WIDTH-1:0] w_calc_cur;
    logic [WIDTH-1:0] w_calc_step;
    logic [WIDTH-1:0] w_calc_bound;
    logic [WIDTH-1:0] w_next;
    logic             w_in_range;

    assign w_triple_vld = start_valid & step_valid & bound_valid;

    // One compare/advance unit serves both the capture check and the
    // per-iteration step. In IDLE it sees (start + 0) vs bound, which is the
    // plain start < bound test and yields next == start for capture.
    assign w_calc_cur   = (r_state == S_IDLE) ? start_data : r_cur;
    assign w_calc_step  = (r_state == S_IDLE) ? '0         : r_step;
    assign w_calc_bound = (r_state == S_IDLE) ? bound_data : r_bound;

    dataflow_stream_next #(
        .WIDTH    (WIDTH)
    ) u_next (
        .cur      (w_calc_cur),
        .step     (w_calc_step),
        .bound    (w_calc_bound),
        .next     (w_next),
        .in_range (w_in_range)
    );

    // Handshake bookkeeping: an output counts as done for this iteration once
    // it was accepted earlier (sent flag) or is being accepted now.
    assign w_idx_fire  = idx_valid & idx_ready;
    assign w_cont_fire = cont_valid & cont_ready;
    assign w_idx_done  = r_idx_sent | w_idx_fire;
    assign w_cont_done = r_cont_sent | w_cont_fire;
    assign w_capture   = (r_state == S_IDLE) & w_triple_vld;
    assign w_advance   = (r_state == S_RUN) & w_idx_done & w_cont_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        step_ready  = 1'b0;
        bound_ready = 1'b0;
        idx_valid   = 1'b0;
        cont_valid  = 1'b0;
        cont_data   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // All-or-nothing join: no input is consumed on its own.
                start_ready = w_triple_vld;
                step_ready  = w_triple_vld;
                bound_ready = w_triple_vld;
                if (w_capture) begin
                    w_state_nxt = w_in_range ? S_RUN : S_LAST;
                end
            end
            S_RUN: begin
                idx_valid  = ~r_idx_sent;
                cont_valid = ~r_cont_sent;
                cont_data  = 1'b1;
                if (w_advance) begin
                    w_state_nxt = w_in_range ? S_RUN : S_LAST;
                end
            end
            S_LAST: begin
                cont_valid = 1'b1;
                cont_data  = 1'b0;
                if (cont_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign idx_data = r_cur;

    // Loop registers and per-output sent flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur       <= '0;
            r_step      <= '0;
            r_bound     <= '0;
            r_idx_sent  <= 1'b0;
            r_cont_sent <= 1'b0;
        end else if (w_capture) begin
            r_cur       <= w_next;
            r_step      <= step_data;
            r_bound     <= bound_data;
            r_idx_sent  <= 1'b0;
            r_cont_sent <= 1'b0;
        end else if (w_advance) begin
            r_cur       <= w_next;
            r_idx_sent  <= 1'b0;
            r_cont_sent <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_idx_sent  <= w_idx_done;
            r_cont_sent <= w_cont_done;
        end
    end

endmodule : dataflow_stream
